// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that serialises JK commands from NREQ requesters onto one
// shared bank of WIDTH JK flip-flops; each command takes an IDLE and an APPLY cycle.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SELW-1:0]    req_sel,
  input  logic [NREQ*2-1:0]       req_cmd,
  output logic [NREQ-1:0]         req_ack,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qbar,
  output logic                    busy,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, APPLY} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [IDW-1:0]   cand;
  logic             found;

  logic [SELW-1:0]  sel_a [NREQ];
  logic [1:0]       cmd_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign sel_a[g] = req_sel[g*SELW +: SELW];
    assign cmd_a[g] = req_cmd[g*2 +: 2];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    cmd_d   = cmd_q;
    bank_d  = bank_q;
    ack_d   = '0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    cand    = '0;
    found   = 1'b0;

    case (state_q)
      IDLE: begin
        // Search starts just after the last winner and wraps, giving rotating priority.
        for (int k = 1; k <= NREQ; k++) begin
          cand = IDW'((int'(ptr_q) + k) % NREQ);
          if (!found && req_valid[cand]) begin
            found = 1'b1;
            win_d = cand;
            sel_d = sel_a[cand];
            cmd_d = cmd_a[cand];
          end
        end
        if (found) begin
          state_d      = APPLY;
          ack_d[win_d] = 1'b1;
          busy_d       = 1'b1;
          err_d        = (int'(sel_d) >= WIDTH);
        end
      end
      APPLY: begin
        // err_q doubles as the out-of-range flag, leaving the bank untouched.
        for (int b = 0; b < WIDTH; b++) begin
          if (!err_q && sel_q == SELW'(b))
            bank_d[b] = (cmd_q[1] & ~bank_q[b]) | (~cmd_q[0] & bank_q[b]);
        end
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      win_q   <= '0;
      sel_q   <= '0;
      cmd_q   <= '0;
      bank_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign req_ack  = ack_q;
  assign q        = bank_q;
  assign qbar     = ~bank_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign grant_id = win_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: an 8-bit and a 6-bit bank share one set of requesters
// and are checked every cycle against a transaction-level model plus directed sequences.
module tb_jk_bank_arbiter;
  localparam int NREQ = 4;
  localparam int SELW = 3;

  typedef struct {
    int   sel;
    int   cmd;
    logic exp_q3;
  } cov_vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*SELW-1:0] req_sel = '0;
  logic [NREQ*2-1:0]    req_cmd = '0;

  logic [NREQ-1:0] ack8, ack6;
  logic [7:0]      q8, qbar8;
  logic [5:0]      q6, qbar6;
  logic            busy8, busy6, err8, err6;
  logic [1:0]      gid8, gid6;

  int n_checks = 0;
  int n_fail   = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_cmd(req_cmd),
    .req_ack(ack8), .q(q8), .qbar(qbar8), .busy(busy8), .err(err8), .grant_id(gid8)
  );

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_cmd(req_cmd),
    .req_ack(ack6), .q(q6), .qbar(qbar6), .busy(busy6), .err(err6), .grant_id(gid6)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction at a time, round-robin from the last grant.
  int          m_pend = -1;
  int          m_last = NREQ - 1;
  int          m_sel  = 0;
  int          m_cmd  = 0;
  int          m_gid  = 0;
  logic [31:0] m_bank8 = '0;
  logic [31:0] m_bank6 = '0;

  function automatic logic [31:0] apply_cmd(input logic [31:0] bank, input int sel,
                                            input int cmd, input int width);
    logic [31:0] res;
    logic [31:0] mask;
    res = bank;
    if (sel < width) begin
      mask = 32'd1 << sel;
      case (cmd)
        1:       res = bank & ~mask;
        2:       res = bank | mask;
        3:       res = bank ^ mask;
        default: res = bank;
      endcase
    end
    return res;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend  = -1;
      m_last  = NREQ - 1;
      m_gid   = 0;
      m_bank8 = '0;
      m_bank6 = '0;
    end else if (m_pend >= 0) begin
      m_bank8 = apply_cmd(m_bank8, m_sel, m_cmd, 8);
      m_bank6 = apply_cmd(m_bank6, m_sel, m_cmd, 6);
      m_last  = m_pend;
      m_pend  = -1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_pend < 0 && req_valid[(m_last + k) % NREQ]) begin
          m_pend = (m_last + k) % NREQ;
          m_gid  = m_pend;
          m_sel  = int'(req_sel[m_pend*SELW +: SELW]);
          m_cmd  = int'(req_cmd[m_pend*2 +: 2]);
        end
      end
    end
  end

  logic [NREQ-1:0] e_ack;
  logic            e_busy;
  logic [7:0]      e_q8, e_qb8;
  logic [5:0]      e_q6, e_qb6;

  always @(negedge clk) begin
    e_ack  = (m_pend >= 0) ? (NREQ'(1) << m_pend) : '0;
    e_busy = (m_pend >= 0);
    e_q8   = m_bank8[7:0];
    e_qb8  = ~e_q8;
    e_q6   = m_bank6[5:0];
    e_qb6  = ~e_q6;
    check("mon_ack8", ack8, e_ack);
    check("mon_ack6", ack6, e_ack);
    check("mon_busy8", busy8, e_busy);
    check("mon_busy6", busy6, e_busy);
    check("mon_err8", err8, e_busy && m_sel >= 8);
    check("mon_err6", err6, e_busy && m_sel >= 6);
    check("mon_q8", q8, e_q8);
    check("mon_q6", q6, e_q6);
    check("mon_qbar8", qbar8, e_qb8);
    check("mon_qbar6", qbar6, e_qb6);
    check("mon_gid8", gid8, m_gid[1:0]);
    check("mon_gid6", gid6, m_gid[1:0]);
  end

  task automatic drive(input int r, input int sel, input int cmd);
    req_valid[r]            = 1'b1;
    req_sel[r*SELW +: SELW] = SELW'(sel);
    req_cmd[r*2 +: 2]       = 2'(cmd);
  endtask

  // Returns the ack vector and how many negedges passed before it appeared.
  task automatic wait_any_ack(output logic [NREQ-1:0] a, output int n);
    a = '0;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack8 != '0) begin
        a = ack8;
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no req_ack, expected one within 40 cycles");
    end
  endtask

  cov_vec_t        cov[5];
  logic [NREQ-1:0] a;
  int              n;
  logic [7:0]      qinv;
  logic [5:0]      q6_before;
  logic [NREQ-1:0] ack_seen;

  initial begin
    cov[0] = '{3, 2, 1'b1};
    cov[1] = '{3, 3, 1'b0};
    cov[2] = '{3, 3, 1'b1};
    cov[3] = '{3, 1, 1'b0};
    cov[4] = '{3, 0, 1'b0};

    #1 rst = 1'b0;
    #1;
    check("rst_q", q8, 8'h00);
    check("rst_qbar", qbar8, 8'hFF);
    check("rst_ack", ack8, '0);
    check("rst_busy", busy8, 1'b0);
    check("rst_err", err6, 1'b0);
    check("rst_gid", gid8, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Fairness: everyone toggles its own bit continuously.
    for (int i = 0; i < NREQ; i++) drive(i, i, 3);
    for (int g = 0; g < 8; g++) begin
      wait_any_ack(a, n);
      check("fair_ack", a, 4'b0001 << (g % NREQ));
      check("fair_gap", n, 1);
      @(posedge clk);
      #1;
      if (g == 3) check("fair_q4", q8, 8'h0F);
      if (g == 7) check("fair_q8", q8, 8'h00);
    end
    req_valid = '0;

    // Command coverage on requester 0, bit 3.
    for (int i = 0; i < 5; i++) begin
      drive(0, cov[i].sel, cov[i].cmd);
      wait_any_ack(a, n);
      check("cov_ack", a, 4'b0001);
      check("cov_lat", n, 1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      qinv = ~q8;
      check("cov_q3", q8[3], cov[i].exp_q3);
      check("cov_qbar", qbar8, qinv);
    end

    // Two requesters fight over bit 5.
    drive(1, 5, 2);
    drive(2, 5, 1);
    wait_any_ack(a, n);
    check("cont_first", a, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    check("cont_q5_set", q8[5], 1'b1);
    wait_any_ack(a, n);
    check("cont_second", a, 4'b0100);
    check("cont_lat", n, 1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    check("cont_q5_clr", q8[5], 1'b0);

    // Out-of-range select on the 6-bit bank (in range for the 8-bit one).
    q6_before = q6;
    drive(3, 7, 2);
    wait_any_ack(a, n);
    check("oor_ack", a, 4'b1000);
    check("oor_err6", err6, 1'b1);
    check("oor_err8", err8, 1'b0);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    check("oor_q6", q6, q6_before);
    check("oor_q8_b7", q8[7], 1'b1);
    @(negedge clk);
    check("oor_err_pulse", err6, 1'b0);
    @(posedge clk);
    #1;

    // Command changed during APPLY must not affect the granted operation.
    drive(0, 2, 2);
    wait_any_ack(a, n);
    check("late_ack1", a, 4'b0001);
    req_cmd[1:0] = 2'b01;
    @(posedge clk);
    #1;
    check("late_q2_set", q8[2], 1'b1);
    wait_any_ack(a, n);
    check("late_ack2", a, 4'b0001);
    check("late_lat", n, 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("late_q2_clr", q8[2], 1'b0);

    // Random traffic obeying the hold-until-ack handshake.
    ack_seen = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ack_seen = ack8;
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] || ack_seen[r]) begin
          req_valid[r]            = ($urandom_range(0, 9) < 6);
          req_sel[r*SELW +: SELW] = SELW'($urandom_range(0, 7));
          req_cmd[r*2 +: 2]       = 2'($urandom_range(0, 3));
        end
      end
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted in the middle of APPLY.
    drive(0, 0, 2);
    @(posedge clk);
    #2;
    check("mid_busy", busy8, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_q8", q8, 8'h00);
    check("mid_qbar8", qbar8, 8'hFF);
    check("mid_q6", q6, 6'h00);
    check("mid_qbar6", qbar6, 6'h3F);
    check("mid_busy0", busy8, 1'b0);
    check("mid_ack", ack8, '0);
    check("mid_err", err6, 1'b0);
    check("mid_gid", gid8, 2'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_q", q8, 8'h00);
      check("post_ack", ack8, '0);
      check("post_busy", busy8, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
